// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run control, decoder strobes and PC outputs.
// master drives Start/Halt/decoder inputs; slave is the sequencer.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
);
  logic                 Start;
  logic                 Halt;
  logic                 ReadMem;
  logic                 WriteMem;
  logic                 BranchEnable;
  logic                 BranchTaken;
  logic [PC_WIDTH-1:0]  BranchTarget;
  logic [PC_WIDTH-1:0]  ProgCounter;
  logic                 Commit;
  logic                 Busy;
  logic                 Done;
  logic [CNT_WIDTH-1:0] CycleCount;

  modport master (
    output Start, Halt, ReadMem, WriteMem,
    output BranchEnable, BranchTaken, BranchTarget,
    input  ProgCounter, Commit, Busy, Done, CycleCount
  );

  modport slave (
    input  Start, Halt, ReadMem, WriteMem,
    input  BranchEnable, BranchTaken, BranchTarget,
    output ProgCounter, Commit, Busy, Done, CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and run control for the accumulator core front end.
// Ports: CLK, Reset (async high), bus (slave): strobes in, PC/Commit/status out.
module fetch_sequencer #(
  parameter int PC_WIDTH  = 10,
  parameter int MEM_WAIT  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic CLK,
  input  logic Reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    Idle,
    Run,
    MemWait,
    Halted
  } state_t;

  localparam bit HasWait = (MEM_WAIT > 0);
  localparam logic [3:0] WaitInit =
    4'(HasWait ? MEM_WAIT - 1 : 0);

  state_t               state, stateNext;
  logic [PC_WIDTH-1:0]  pc, pcNext;
  logic [3:0]           waitCnt, waitNext;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 commit;
  logic                 clearCnt;
  logic                 busy;
  logic                 memOp;

  assign memOp = bus.ReadMem | bus.WriteMem;
  assign busy  = (state == Run) || (state == MemWait);

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    waitNext  = waitCnt;
    commit    = 1'b0;
    clearCnt  = 1'b0;
    unique case (state)
      Idle, Halted: begin
        if (bus.Start) begin
          stateNext = Run;
          pcNext    = '0;
          clearCnt  = 1'b1;
        end
      end
      Run: begin
        if (bus.Halt) begin
          stateNext = Halted;
        end else if (memOp && HasWait) begin
          stateNext = MemWait;
          waitNext  = WaitInit;
        end else begin
          commit = 1'b1;
          if (bus.BranchEnable && bus.BranchTaken)
            pcNext = bus.BranchTarget;
          else
            pcNext = pc + 1'b1;
        end
      end
      MemWait: begin
        if (waitCnt != 4'd0) begin
          waitNext = waitCnt - 4'd1;
        end else begin
          commit    = 1'b1;
          pcNext    = pc + 1'b1;
          stateNext = Run;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= Idle;
      pc      <= '0;
      waitCnt <= 4'd0;
      cnt     <= '0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      waitCnt <= waitNext;
      if (clearCnt)
        cnt <= '0;
      else if (busy && (cnt != {CNT_WIDTH{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.ProgCounter = pc;
  assign bus.Commit      = commit;
  assign bus.Busy        = busy;
  assign bus.Done        = (state == Halted);
  assign bus.CycleCount  = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, hand sequences, random vs model.
// Two instances: default parameters and a narrow PC/counter, no-wait one.
module tb_fetch_sequencer;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  fetch_sequencer_if #(.PC_WIDTH(10), .CNT_WIDTH(16)) busA ();
  fetch_sequencer_if #(.PC_WIDTH(4), .CNT_WIDTH(4)) busB ();

  fetch_sequencer #(.PC_WIDTH(10), .MEM_WAIT(2), .CNT_WIDTH(16)) dutA (
    .CLK(CLK), .Reset(Reset), .bus(busA)
  );
  fetch_sequencer #(.PC_WIDTH(4), .MEM_WAIT(0), .CNT_WIDTH(4)) dutB (
    .CLK(CLK), .Reset(Reset), .bus(busB)
  );

  typedef struct {
    bit start, halt, rd, wr, be, bt;
    int tgt;
  } in_t;

  typedef struct {
    in_t x;
    int  pc;
    bit  c, b, d;
    int  cnt;
  } vec_t;

  // mode: 0 idle, 1 running, 2 halted; age: cycle index inside a stalled LD/ST
  typedef struct {
    int mode, pc, age, cnt;
  } mdl_t;

  vec_t vec[$];

  function automatic in_t mkIn(bit s, bit h, bit r, bit w,
                               bit e, bit t, int g);
    in_t x;
    x.start = s; x.halt = h; x.rd = r; x.wr = w;
    x.be = e; x.bt = t; x.tgt = g;
    return x;
  endfunction

  function automatic vec_t mk(in_t x, int pc, bit c, bit b,
                              bit d, int cnt);
    vec_t v;
    v.x = x; v.pc = pc; v.c = c; v.b = b; v.d = d; v.cnt = cnt;
    return v;
  endfunction

  function automatic mdl_t rstM();
    mdl_t m;
    m.mode = 0; m.pc = 0; m.age = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic bit expC(mdl_t m, in_t x, int mw);
    if (m.mode != 1) return 1'b0;
    if (m.age > 0) return (m.age == mw);
    if (x.halt) return 1'b0;
    if ((x.rd || x.wr) && mw > 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic mdl_t stepM(mdl_t m, in_t x, int pcw,
                                 int mw, int cmax);
    mdl_t n = m;
    int md = 1 << pcw;
    if (m.mode != 1) begin
      if (x.start) begin
        n.mode = 1; n.pc = 0; n.cnt = 0; n.age = 0;
      end
      return n;
    end
    n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
    if (m.age > 0) begin
      if (m.age == mw) begin
        n.age = 0;
        n.pc = (m.pc + 1) % md;
      end else begin
        n.age = m.age + 1;
      end
    end else if (x.halt) begin
      n.mode = 2;
    end else if ((x.rd || x.wr) && mw > 0) begin
      n.age = 1;
    end else if (x.be && x.bt) begin
      n.pc = x.tgt;
    end else begin
      n.pc = (m.pc + 1) % md;
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drvA(in_t x);
    busA.Start = x.start; busA.Halt = x.halt;
    busA.ReadMem = x.rd; busA.WriteMem = x.wr;
    busA.BranchEnable = x.be; busA.BranchTaken = x.bt;
    busA.BranchTarget = 10'(x.tgt);
  endtask

  task automatic drvB(in_t x);
    busB.Start = x.start; busB.Halt = x.halt;
    busB.ReadMem = x.rd; busB.WriteMem = x.wr;
    busB.BranchEnable = x.be; busB.BranchTaken = x.bt;
    busB.BranchTarget = 4'(x.tgt);
  endtask

  task automatic chkA(string nm, int pc, bit c, bit b, bit d, int cnt);
    chk({nm, ".pc"}, 32'(busA.ProgCounter), pc);
    chk({nm, ".commit"}, 32'(busA.Commit), 32'(c));
    chk({nm, ".busy"}, 32'(busA.Busy), 32'(b));
    chk({nm, ".done"}, 32'(busA.Done), 32'(d));
    chk({nm, ".cnt"}, 32'(busA.CycleCount), cnt);
  endtask

  task automatic chkB(string nm, int pc, bit c, bit b, bit d, int cnt);
    chk({nm, ".pc"}, 32'(busB.ProgCounter), pc);
    chk({nm, ".commit"}, 32'(busB.Commit), 32'(c));
    chk({nm, ".busy"}, 32'(busB.Busy), 32'(b));
    chk({nm, ".done"}, 32'(busB.Done), 32'(d));
    chk({nm, ".cnt"}, 32'(busB.CycleCount), cnt);
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in_t z, p, s, rdI;
    mdl_t ma, mb;
    z   = mkIn(0, 0, 0, 0, 0, 0, 0);
    p   = z;
    s   = mkIn(1, 0, 0, 0, 0, 0, 0);
    rdI = mkIn(0, 0, 1, 0, 0, 0, 0);
    drvA(z);
    drvB(z);

    // program run, LD stall, branches, halt+branch priority
    vec.push_back(mk(s, 0, 0, 0, 0, 0));
    vec.push_back(mk(p, 0, 1, 1, 0, 0));
    vec.push_back(mk(p, 1, 1, 1, 0, 1));
    vec.push_back(mk(p, 2, 1, 1, 0, 2));
    vec.push_back(mk(p, 3, 1, 1, 0, 3));
    vec.push_back(mk(mkIn(0, 1, 0, 0, 0, 0, 0), 4, 0, 1, 0, 4));
    vec.push_back(mk(z, 4, 0, 0, 1, 5));
    vec.push_back(mk(s, 4, 0, 0, 1, 5));
    vec.push_back(mk(p, 0, 1, 1, 0, 0));
    vec.push_back(mk(s, 1, 1, 1, 0, 1));
    vec.push_back(mk(s, 2, 1, 1, 0, 2));
    vec.push_back(mk(rdI, 3, 0, 1, 0, 3));
    vec.push_back(mk(rdI, 3, 0, 1, 0, 4));
    vec.push_back(mk(rdI, 3, 1, 1, 0, 5));
    vec.push_back(mk(p, 4, 1, 1, 0, 6));
    vec.push_back(mk(p, 5, 1, 1, 0, 7));
    vec.push_back(mk(p, 6, 1, 1, 0, 8));
    vec.push_back(mk(mkIn(0, 0, 0, 0, 1, 1, 2), 7, 1, 1, 0, 9));
    vec.push_back(mk(p, 2, 1, 1, 0, 10));
    vec.push_back(mk(p, 3, 1, 1, 0, 11));
    vec.push_back(mk(mkIn(0, 0, 0, 1, 0, 0, 0), 4, 0, 1, 0, 12));
    vec.push_back(mk(z, 4, 0, 1, 0, 13));
    vec.push_back(mk(z, 4, 1, 1, 0, 14));
    vec.push_back(mk(p, 5, 1, 1, 0, 15));
    vec.push_back(mk(p, 6, 1, 1, 0, 16));
    vec.push_back(mk(mkIn(0, 0, 0, 0, 1, 0, 2), 7, 1, 1, 0, 17));
    vec.push_back(mk(mkIn(0, 0, 0, 0, 1, 1, 7), 8, 1, 1, 0, 18));
    vec.push_back(mk(mkIn(0, 0, 0, 0, 1, 1, 7), 7, 1, 1, 0, 19));
    vec.push_back(mk(mkIn(0, 1, 0, 0, 1, 1, 2), 7, 0, 1, 0, 20));
    vec.push_back(mk(z, 7, 0, 0, 1, 21));

    #12 Reset = 1'b0;
    nextCycle();
    chkA("reset", 0, 0, 0, 0, 0);

    foreach (vec[i]) begin
      drvA(vec[i].x);
      @(negedge CLK);
      chkA($sformatf("vec%0d", i), vec[i].pc, vec[i].c,
           vec[i].b, vec[i].d, vec[i].cnt);
      nextCycle();
    end

    // async reset in the middle of a run at PC 5
    drvA(s);
    nextCycle();
    drvA(p);
    repeat (5) nextCycle();
    @(negedge CLK);
    chk("prerst.pc", 32'(busA.ProgCounter), 5);
    #2 Reset = 1'b1;
    #1 chkA("midrst", 0, 0, 0, 0, 0);
    #1 Reset = 1'b0;
    drvA(z);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chkA($sformatf("idle%0d", i), 0, 0, 0, 0, 0);
    end
    nextCycle();

    // narrow instance: zero-wait LD, PC wrap and counter saturation
    drvB(s);
    nextCycle();
    for (int i = 0; i < 20; i++) begin
      drvB(i == 3 ? rdI : p);
      @(negedge CLK);
      chkB($sformatf("wrap%0d", i), i % 16, 1, 1, 0,
           (i < 15) ? i : 15);
      nextCycle();
    end
    drvB(z);

    // random traffic against the model on both instances
    Reset = 1'b1;
    #1 Reset = 1'b0;
    ma = rstM();
    mb = rstM();
    for (int i = 0; i < 3000; i++) begin
      in_t xa, xb;
      bit r;
      r = ($urandom_range(0, 199) == 0);
      xa = mkIn($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, 1'($urandom),
                $urandom_range(0, 1023));
      xb = mkIn($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) == 0, 1'b0,
                $urandom_range(0, 3) == 0, 1'($urandom),
                $urandom_range(0, 15));
      Reset = r;
      drvA(xa);
      drvB(xb);
      if (r) begin
        ma = rstM();
        mb = rstM();
      end
      @(negedge CLK);
      chkA($sformatf("rndA%0d", i), ma.pc, expC(ma, xa, 2),
           ma.mode == 1, ma.mode == 2, ma.cnt);
      chkB($sformatf("rndB%0d", i), mb.pc, expC(mb, xb, 0),
           mb.mode == 1, mb.mode == 2, mb.cnt);
      @(posedge CLK);
      if (!r) begin
        ma = stepM(ma, xa, 10, 2, 65535);
        mb = stepM(mb, xb, 4, 0, 15);
      end
      #1;
    end
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
